lux_avg: RTL
============

// Module: lux_avg
// PURPOSE
//  Downstream stage of the SPI luxmeter sensor controller. Consumes raw light
//  samples (one per SPI conversion) over a valid/ready handshake.
//  Averages each block of 2^LOG2_N samples with round-half-up.
//  Presents the mean to the display/report logic over a second valid/ready
//  handshake.
// PARAMETERS
//  DATA_W  8  width of a raw sample and of the averaged result
//  LOG2_N  4  log2 of samples per average (N=16); LOG2_N=0 -> pass-through
// PORTS
//  clk      in   1          system clock, all logic on rising edge
//  rst      in   1          asynchronous, active-high reset
//  clear    in   1          sync: discard partial block, return to ACCUM
//  s_valid  in   1          sample from spi_sensor is valid
//  s_ready  out  1          block accepts sample this cycle
//  s_data   in   DATA_W     raw light sample
//  m_valid  out  1          averaged result valid
//  m_ready  in   1          consumer accepts result
//  m_data   out  DATA_W     averaged result
//  m_min    out  DATA_W     minimum sample in the block
//  m_max    out  DATA_W     maximum sample in the block
// BEHAVIOUR
//  - Reset: state=ACCUM, acc=0, cnt=0, s_ready=1, m_valid=0,
//    m_data/m_min/m_max=0, run_min=all ones, run_max=0.
//  - States:
//    - ACCUM: s_ready=1. Sample accepted on s_valid&s_ready.
//      - acc+=s_data, cnt+=1, run_min/run_max updated (sample included).
//      - When the accepted sample is the Nth (cnt==N-1): latch results, clear
//        acc/cnt/run_min/run_max, go to OUTPUT.
//    - OUTPUT: s_ready=0, m_valid=1, m_data/m_min/m_max held stable.
//      - On m_valid&m_ready: go to ACCUM (m_valid=0 next cycle).
//  - Latency: m_valid rises the cycle after the Nth sample is accepted.
//  - Throughput: one idle s_ready-low cycle minimum per block.
//  - Width rules:
//    - acc is DATA_W+LOG2_N bits unsigned; cnt is LOG2_N bits and wraps N-1->0.
//    - m_data = (acc_final + 2^(LOG2_N-1)) >> LOG2_N, with offset 0 if
//      LOG2_N==0. acc_final includes the Nth sample.
//    - The sum fits in DATA_W+LOG2_N bits: max result = 2^DATA_W-1, so there
//      is no saturation path.
//  - Handshake rules:
//    - s_data is sampled only when s_valid&s_ready.
//    - m_* outputs do not change while m_valid=1 and m_ready=0.
//    - m_valid never drops without m_ready.
//  - Simultaneous events:
//    - In OUTPUT, s_valid is ignored because s_ready=0. No sample is lost; the
//      producer holds it.
//    - clear in ACCUM wins over an accepted sample (sample dropped; acc=0,
//      cnt=0, extrema reset).
//    - clear in OUTPUT has no effect on the pending result; it takes effect
//      only when acc/cnt are already zero.
//  - Reset mid-block or mid-OUTPUT: all state cleared immediately
//    (asynchronous); the pending result is lost.
// STRUCTURE
//  - Shared include lux_defs.vh: DATA_W and LOG2_N defaults, state encodings
//    ST_ACCUM=1'b0, ST_OUTPUT=1'b1. spi_sensor and the display stage reuse it.
//  - Single flat module; no sub-module.
//  - The rounding divide is a constant shift, coded inline.
// TESTING
//  1. Reset: assert rst mid-block after 5 samples -> m_valid=0, s_ready=1;
//     the next 16 samples form a fresh block.
//  2. 16 samples all 8'd100 -> m_data=100, m_min=100, m_max=100; m_valid
//     one cycle after the 16th.
//  3. Samples 0..15 -> sum=120, (120+8)>>4 = 8; m_min=0, m_max=15.
//  4. 16 samples of 8'd255 -> m_data=255 (no overflow).
//     15x0 + 1x8 -> (8+8)>>4 = 1 (round-half-up).
//  5. Hold m_ready=0 for 10 cycles with s_valid=1 -> s_ready=0 and m_* stable
//     throughout. After m_ready=1, the next block counts from the following
//     sample.
//  6. clear after 7 samples, then 16x8'd50 -> m_data=50.
//     LOG2_N=0 build: each sample is echoed one cycle later.

Source files
------------

// File: rtl/lux_avg_pkg.sv
// Shared definitions for the luxmeter averaging stage: default widths and
// the two-state controller encoding.
package lux_avg_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_LOG2_N = 4;

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_OUTPUT = 1'b1
    } state_e;

endpackage

// File: rtl/lux_avg_if.sv
// Sample-in / result-out handshake bundle for lux_avg. The master side is
// the environment (sample producer + result consumer); the slave side is
// the averaging block.
interface lux_avg_if
    import lux_avg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] m_min;
    logic [DATA_W-1:0] m_max;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_min, m_max
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_min, m_max
    );

endinterface

// File: rtl/lux_avg.sv
// Block averager for the luxmeter: sums 2^LOG2_N accepted samples, emits the
// round-half-up mean together with the block minimum and maximum, and holds
// the result until the consumer takes it.
module lux_avg
    import lux_avg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LOG2_N = DEF_LOG2_N
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    lux_avg_if.slave   bus
);

    localparam int N     = 1 << LOG2_N;
    localparam int ACC_W = DATA_W + LOG2_N;
    localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
    localparam int HALF  = N / 2;

    typedef logic [DATA_W-1:0] data_t;

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    data_t             run_min_q, run_min_d;
    data_t             run_max_q, run_max_d;
    data_t             m_data_q, m_data_d;
    data_t             m_min_q, m_min_d;
    data_t             m_max_q, m_max_d;

    logic              accept;
    logic              last_smp;
    logic [ACC_W-1:0]  sum;
    data_t             smp_min;
    data_t             smp_max;

    // Rounding divide by N: add half an LSB of the result, then shift. The
    // extra top bit keeps the carry of the offset add.
    function automatic data_t round_mean(input logic [ACC_W-1:0] total);
        logic [ACC_W:0] t;
        t = {1'b0, total} + (ACC_W + 1)'(HALF);
        return DATA_W'(t >> LOG2_N);
    endfunction

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave ACCUM on the Nth accepted sample (unless clear drops
    // it), leave OUTPUT when the consumer takes the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: begin
                if (!clear && accept && last_smp) begin
                    state_d = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                if (bus.m_ready) begin
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // Handshake outputs are decoded directly from the state.
    always_comb begin
        bus.s_ready = (state_q == ST_ACCUM);
        bus.m_valid = (state_q == ST_OUTPUT);
    end

    // Accumulator, counter, running extrema and result registers next values.
    // clear also fires in OUTPUT, where the accumulator is already zero, so
    // the pending result is never disturbed.
    always_comb begin
        accept    = (state_q == ST_ACCUM) && bus.s_valid;
        last_smp  = (LOG2_N == 0) || (cnt_q == CNT_W'(N - 1));
        sum       = acc_q + ACC_W'(bus.s_data);
        smp_min   = (bus.s_data < run_min_q) ? bus.s_data : run_min_q;
        smp_max   = (bus.s_data > run_max_q) ? bus.s_data : run_max_q;

        acc_d     = acc_q;
        cnt_d     = cnt_q;
        run_min_d = run_min_q;
        run_max_d = run_max_q;
        m_data_d  = m_data_q;
        m_min_d   = m_min_q;
        m_max_d   = m_max_q;

        if (clear) begin
            acc_d     = '0;
            cnt_d     = '0;
            run_min_d = '1;
            run_max_d = '0;
        end else if (accept) begin
            if (last_smp) begin
                m_data_d  = round_mean(sum);
                m_min_d   = smp_min;
                m_max_d   = smp_max;
                acc_d     = '0;
                cnt_d     = '0;
                run_min_d = '1;
                run_max_d = '0;
            end else begin
                acc_d     = sum;
                cnt_d     = cnt_q + 1'b1;
                run_min_d = smp_min;
                run_max_d = smp_max;
            end
        end
    end

    // Datapath registers; reset drops any partial block and pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            run_min_q <= '1;
            run_max_q <= '0;
            m_data_q  <= '0;
            m_min_q   <= '0;
            m_max_q   <= '0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            run_min_q <= run_min_d;
            run_max_q <= run_max_d;
            m_data_q  <= m_data_d;
            m_min_q   <= m_min_d;
            m_max_q   <= m_max_d;
        end
    end

    assign bus.m_data = m_data_q;
    assign bus.m_min  = m_min_q;
    assign bus.m_max  = m_max_q;

endmodule
